// File: rtl/sw_pkg.sv
// Shared definitions for the Smith-Waterman systolic array host side.
// Holds the datapath widths, the driver state encoding and the symbol
// encoding / substitution constants that the PE score lookup also uses.
package sw_pkg;

    localparam int SYM_W   = 3;
    localparam int SCORE_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_Q,
        STREAM_T,
        DRAIN,
        DONE
    } sw_state_e;

    // Symbol 0 is the null symbol seen by an idle PE; 1..7 are residues.
    localparam logic [SYM_W-1:0] SYM_NULL = 3'd0;
    localparam logic [SYM_W-1:0] SYM_A    = 3'd1;
    localparam logic [SYM_W-1:0] SYM_C    = 3'd2;
    localparam logic [SYM_W-1:0] SYM_G    = 3'd3;
    localparam logic [SYM_W-1:0] SYM_T    = 3'd4;

    // Linear-gap scoring used by every PE.
    localparam int MATCH_SCORE  = 2;
    localparam int MISMATCH_PEN = 1;
    localparam int GAP_PEN      = 1;

endpackage

// File: rtl/sw_array_driver.sv
// Host-side transmitter for the Smith-Waterman PE chain.
// Loads a NUM_PE-symbol query into the chain, streams a target into PE[0]
// with a per-symbol init flag, drains the pipeline and reports the largest
// max_out value seen from the last PE.
//
// Ports:
//   clk, reset_i                      clock, synchronous active-high reset
//   start_i                           begins a run (only honoured in IDLE)
//   q_valid_i/q_ready_o/q_sym_i       query symbol stream
//   t_valid_i/t_ready_o/t_sym_i/t_last_i  target symbol stream
//   shift_valid_s_o, s_o, valid_s_o   query shift into the chain
//   t_o, init_o                       target symbol / cell-active to PE[0]
//   max_o, v_o, f_o                   PE[0] boundary values (always 0)
//   max_i                             max_out of the last PE
//   score_o, score_valid_o            final score and its one-cycle strobe
//   busy_o, err_o                     run in progress, sticky bubble error
module sw_array_driver
    import sw_pkg::*;
#(
    parameter int NUM_PE = 16
) (
    input  logic               clk,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic               q_valid_i,
    output logic               q_ready_o,
    input  logic [SYM_W-1:0]   q_sym_i,
    input  logic               t_valid_i,
    output logic               t_ready_o,
    input  logic [SYM_W-1:0]   t_sym_i,
    input  logic               t_last_i,
    output logic               shift_valid_s_o,
    output logic [SYM_W-1:0]   s_o,
    output logic               valid_s_o,
    output logic [SYM_W-1:0]   t_o,
    output logic               init_o,
    output logic [SCORE_W-1:0] max_o,
    output logic [SCORE_W-1:0] v_o,
    output logic [SCORE_W-1:0] f_o,
    input  logic [SCORE_W-1:0] max_i,
    output logic [SCORE_W-1:0] score_o,
    output logic               score_valid_o,
    output logic               busy_o,
    output logic               err_o
);

    // One counter width covers both the query index and the drain count.
    localparam int CNT_W = $clog2(NUM_PE + 2);
    localparam logic [CNT_W-1:0] Q_LAST = CNT_W'(NUM_PE - 1);
    localparam logic [CNT_W-1:0] D_LAST = CNT_W'(NUM_PE + 1);

    sw_state_e          state_q, state_d;
    logic [CNT_W-1:0]   q_cnt_q, q_cnt_d;
    logic [CNT_W-1:0]   d_cnt_q, d_cnt_d;
    logic [SCORE_W-1:0] run_max_q, run_max_d;
    logic [SYM_W-1:0]   s_q, s_d;
    logic               shift_q, shift_d;
    logic [SYM_W-1:0]   t_q, t_d;
    logic               init_q, init_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic               score_valid_q, score_valid_d;
    logic               err_q, err_d;
    logic [SCORE_W-1:0] max_upd;

    // Unsigned running max; idle PEs return 0 so they never win.
    assign max_upd = (max_i > run_max_q) ? max_i : run_max_q;

    always_comb begin
        state_d       = state_q;
        q_cnt_d       = q_cnt_q;
        d_cnt_d       = d_cnt_q;
        run_max_d     = run_max_q;
        s_d           = s_q;
        shift_d       = 1'b0;
        t_d           = t_q;
        init_d        = 1'b0;
        score_d       = score_q;
        score_valid_d = 1'b0;
        err_d         = err_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d   = LOAD_Q;
                    err_d     = 1'b0;
                    run_max_d = '0;
                    q_cnt_d   = '0;
                end
            end
            LOAD_Q: begin
                if (q_valid_i) begin
                    s_d     = q_sym_i;
                    shift_d = 1'b1;
                    q_cnt_d = q_cnt_q + 1'b1;
                    if (q_cnt_q == Q_LAST) state_d = STREAM_T;
                end
            end
            STREAM_T: begin
                run_max_d = max_upd;
                d_cnt_d   = '0;
                if (t_valid_i) begin
                    t_d    = t_sym_i;
                    init_d = 1'b1;
                    if (t_last_i) state_d = DRAIN;
                end else begin
                    // A gap in the target stream would corrupt the
                    // anti-diagonal timing: flag it and finish the run.
                    err_d   = 1'b1;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                run_max_d = max_upd;
                d_cnt_d   = d_cnt_q + 1'b1;
                if (d_cnt_q == D_LAST) state_d = DONE;
            end
            DONE: begin
                score_d       = run_max_q;
                score_valid_d = 1'b1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state_q       <= IDLE;
            q_cnt_q       <= '0;
            d_cnt_q       <= '0;
            run_max_q     <= '0;
            s_q           <= '0;
            shift_q       <= 1'b0;
            t_q           <= '0;
            init_q        <= 1'b0;
            score_q       <= '0;
            score_valid_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            q_cnt_q       <= q_cnt_d;
            d_cnt_q       <= d_cnt_d;
            run_max_q     <= run_max_d;
            s_q           <= s_d;
            shift_q       <= shift_d;
            t_q           <= t_d;
            init_q        <= init_d;
            score_q       <= score_d;
            score_valid_q <= score_valid_d;
            err_q         <= err_d;
        end
    end

    assign q_ready_o       = (state_q == LOAD_Q);
    assign t_ready_o       = (state_q == STREAM_T);
    assign busy_o          = (state_q != IDLE);
    assign shift_valid_s_o = shift_q;
    assign valid_s_o       = shift_q;
    assign s_o             = s_q;
    assign t_o             = t_q;
    assign init_o          = init_q;
    assign max_o           = '0;
    assign v_o             = '0;
    assign f_o             = '0;
    assign score_o         = score_q;
    assign score_valid_o   = score_valid_q;
    assign err_o           = err_q;

endmodule

// File: tb/tb_sw_array_driver.sv
// Randomized self-checking bench for sw_array_driver. The bench plays the
// host and a stub of the PE chain's last max_out; the expected score is the
// max of every max_i value presented while a run is streaming or draining.
module tb_sw_array_driver;
    import sw_pkg::*;

    localparam int NUM_PE = 16;

    logic               clk = 1'b0;
    logic               reset_i, start_i, q_valid_i, t_valid_i, t_last_i;
    logic [SYM_W-1:0]   q_sym_i, t_sym_i, s_o, t_o;
    logic               q_ready_o, t_ready_o, shift_valid_s_o, valid_s_o;
    logic               init_o, score_valid_o, busy_o, err_o;
    logic [SCORE_W-1:0] max_o, v_o, f_o, max_i, score_o;

    always #5 clk = ~clk;

    sw_array_driver #(.NUM_PE(NUM_PE)) dut (
        .clk(clk), .reset_i(reset_i), .start_i(start_i),
        .q_valid_i(q_valid_i), .q_ready_o(q_ready_o), .q_sym_i(q_sym_i),
        .t_valid_i(t_valid_i), .t_ready_o(t_ready_o), .t_sym_i(t_sym_i),
        .t_last_i(t_last_i), .shift_valid_s_o(shift_valid_s_o), .s_o(s_o),
        .valid_s_o(valid_s_o), .t_o(t_o), .init_o(init_o),
        .max_o(max_o), .v_o(v_o), .f_o(f_o), .max_i(max_i),
        .score_o(score_o), .score_valid_o(score_valid_o),
        .busy_o(busy_o), .err_o(err_o)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [SCORE_W-1:0] exp_max;
    logic [SCORE_W-1:0] last_score;
    logic [SCORE_W-1:0] stub_q[$];
    logic [SYM_W-1:0]   qry[NUM_PE];
    logic [SYM_W-1:0]   tgt[64];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present the next chain output for a cycle that the run-max sees.
    task automatic feed_max;
        max_i = (stub_q.size() > 0) ? stub_q.pop_front() : '0;
        if (max_i > exp_max) exp_max = max_i;
    endtask

    task automatic chk_quiet(input string nm);
        chk({nm, ".shift"}, shift_valid_s_o, 0);
        chk({nm, ".valid_s"}, valid_s_o, 0);
        chk({nm, ".s"}, s_o, 0);
        chk({nm, ".t"}, t_o, 0);
        chk({nm, ".init"}, init_o, 0);
        chk({nm, ".bound"}, {max_o, v_o}, 0);
        chk({nm, ".f"}, f_o, 0);
        chk({nm, ".score"}, score_o, 0);
        chk({nm, ".score_valid"}, score_valid_o, 0);
        chk({nm, ".busy"}, busy_o, 0);
        chk({nm, ".err"}, err_o, 0);
        chk({nm, ".rdy"}, {q_ready_o, t_ready_o}, 0);
    endtask

    // Plain Smith-Waterman over the first ncols target symbols.
    function automatic int sw_ref(input int ncols);
        int h[NUM_PE+1][65];
        int best;
        int d;
        best = 0;
        for (int i = 0; i <= NUM_PE; i++)
            for (int j = 0; j <= 64; j++) h[i][j] = 0;
        for (int j = 1; j <= ncols; j++) begin
            for (int i = 1; i <= NUM_PE; i++) begin
                d = h[i-1][j-1] + ((qry[i-1] == tgt[j-1]) ? MATCH_SCORE : -MISMATCH_PEN);
                if (h[i-1][j] - GAP_PEN > d) d = h[i-1][j] - GAP_PEN;
                if (h[i][j-1] - GAP_PEN > d) d = h[i][j-1] - GAP_PEN;
                if (d < 0) d = 0;
                h[i][j] = d;
                if (d > best) best = d;
            end
        end
        return best;
    endfunction

    // One complete run. bubble_at < 0 means no bubble.
    task automatic run(input string nm, input int tlen, input int bubble_at,
                       input int gap, input bit gap_fixed, input bit start_in_drain);
        int  pulses;
        int  g;
        bit  bub;
        start_i = 1'b1;
        max_i   = SCORE_W'($urandom);
        tick;
        start_i = 1'b0;
        chk({nm, ".start_busy"}, busy_o, 1);
        chk({nm, ".start_err"}, err_o, 0);
        chk({nm, ".start_qrdy"}, q_ready_o, 1);
        chk({nm, ".held_score"}, score_o, last_score);
        exp_max = '0;
        pulses  = 0;
        for (int i = 0; i < NUM_PE; i++) begin
            g = gap_fixed ? gap : $urandom_range(gap, 0);
            repeat (g) begin
                q_valid_i = 1'b0;
                q_sym_i   = SYM_W'($urandom);
                max_i     = SCORE_W'($urandom);
                tick;
                pulses += int'(shift_valid_s_o);
                chk({nm, ".gap_shift"}, shift_valid_s_o, 0);
                chk({nm, ".gap_qrdy"}, q_ready_o, 1);
            end
            q_valid_i = 1'b1;
            q_sym_i   = qry[i];
            max_i     = SCORE_W'($urandom);
            tick;
            q_valid_i = 1'b0;
            pulses += int'(shift_valid_s_o);
            chk({nm, ".s"}, s_o, qry[i]);
            chk({nm, ".valid_s"}, valid_s_o, 1);
        end
        chk({nm, ".pulses"}, pulses, NUM_PE);
        chk({nm, ".t_ready_after_q"}, {q_ready_o, t_ready_o}, 2'b01);
        bub = 1'b0;
        for (int i = 0; i < tlen; i++) begin
            if (i == bubble_at) begin
                t_valid_i = 1'b0;
                feed_max;
                tick;
                chk({nm, ".bub_init"}, init_o, 0);
                chk({nm, ".bub_err"}, err_o, 1);
                chk({nm, ".bub_trdy"}, t_ready_o, 0);
                bub = 1'b1;
                break;
            end
            t_valid_i = 1'b1;
            t_sym_i   = tgt[i];
            t_last_i  = (i == tlen - 1);
            feed_max;
            tick;
            chk({nm, ".init"}, init_o, 1);
            chk({nm, ".t"}, t_o, tgt[i]);
            chk({nm, ".err"}, err_o, 0);
            chk({nm, ".trdy"}, t_ready_o, (i == tlen - 1) ? 0 : 1);
        end
        t_valid_i = 1'b0;
        t_last_i  = 1'b0;
        for (int d = 0; d < NUM_PE + 2; d++) begin
            if (start_in_drain && d == 3) start_i = 1'b1;
            feed_max;
            tick;
            start_i = 1'b0;
            chk({nm, ".drain_sv"}, score_valid_o, 0);
            chk({nm, ".drain_busy"}, busy_o, 1);
            chk({nm, ".drain_init"}, {init_o, q_ready_o, t_ready_o}, 0);
            chk({nm, ".drain_err"}, err_o, bub);
        end
        // DONE cycle: this max_i must not reach the score.
        max_i = '1;
        tick;
        chk({nm, ".score_valid"}, score_valid_o, 1);
        chk({nm, ".score"}, score_o, exp_max);
        chk({nm, ".done_busy"}, busy_o, 0);
        chk({nm, ".done_err"}, err_o, bub);
        last_score = exp_max;
        max_i = '0;
        tick;
        chk({nm, ".sv_pulse"}, score_valid_o, 0);
        chk({nm, ".score_hold"}, score_o, last_score);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int tl;
        int bp;
        reset_i = 1'b1; start_i = 1'b0; q_valid_i = 1'b0; t_valid_i = 1'b0;
        t_last_i = 1'b0; q_sym_i = '0; t_sym_i = '0; max_i = '0;
        last_score = '0; exp_max = '0;
        tick; tick;
        chk_quiet("reset");
        reset_i = 1'b0;
        tick;
        chk_quiet("idle");

        // Cyclic query with 2-cycle gaps; stub returns 3,9,5,0 then zeros.
        for (int i = 0; i < NUM_PE; i++) qry[i] = SYM_W'((i % 7) + 1);
        for (int i = 0; i < 4; i++) tgt[i] = SYM_W'($urandom_range(7, 1));
        stub_q = '{16'd3, 16'd9, 16'd5, 16'd0};
        run("cap", 4, -1, 2, 1'b1, 1'b0);
        chk("cap.nine", score_o, 9);

        // Bubble after two symbols, with an ignored start during drain.
        for (int i = 0; i < 6; i++) tgt[i] = SYM_W'($urandom_range(7, 1));
        stub_q.delete();
        for (int i = 0; i < 30; i++) stub_q.push_back(SCORE_W'($urandom_range(500, 0)));
        run("bubble", 6, 2, 1, 1'b0, 1'b1);
        chk("bubble.sticky", err_o, 1);

        // Reset in the middle of streaming the target.
        start_i = 1'b1; tick; start_i = 1'b0;
        for (int i = 0; i < NUM_PE; i++) begin
            q_valid_i = 1'b1; q_sym_i = qry[i]; tick;
        end
        q_valid_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            t_valid_i = 1'b1; t_sym_i = SYM_W'(i + 3); max_i = 16'h1234; tick;
        end
        reset_i = 1'b1;
        tick;
        reset_i = 1'b0; t_valid_i = 1'b0; max_i = '0;
        chk_quiet("midrst");
        for (int i = 0; i < NUM_PE + 6; i++) begin
            tick;
            chk("midrst.no_sv", {score_valid_o, busy_o}, 0);
        end
        last_score = '0;

        // Start and reset together: reset wins.
        reset_i = 1'b1; start_i = 1'b1; tick;
        reset_i = 1'b0; start_i = 1'b0;
        chk("rst_vs_start.busy", busy_o, 0);
        tick;
        chk("rst_vs_start.busy2", busy_o, 0);

        // Randomized runs, including high-bit max values.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NUM_PE; i++) qry[i] = SYM_W'($urandom_range(7, 1));
            tl = $urandom_range(20, 1);
            for (int i = 0; i < tl; i++) tgt[i] = SYM_W'($urandom_range(7, 1));
            bp = ($urandom_range(2, 0) == 0) ? $urandom_range(tl - 1, 0) : -1;
            stub_q.delete();
            for (int i = 0; i < tl + NUM_PE + 2; i++)
                stub_q.push_back(SCORE_W'($urandom));
            run($sformatf("rnd%0d", r), tl, bp, 2, 1'b0, r[0]);
        end

        // End to end: query equal to target, stub models the last PE max_out.
        for (int i = 0; i < NUM_PE; i++) begin
            qry[i] = SYM_W'($urandom_range(7, 1));
            tgt[i] = qry[i];
        end
        stub_q.delete();
        for (int i = 0; i < NUM_PE; i++) stub_q.push_back('0);
        for (int d = 0; d < NUM_PE + 2; d++)
            stub_q.push_back(SCORE_W'(sw_ref((d + 1 < NUM_PE) ? d + 1 : NUM_PE)));
        run("e2e", NUM_PE, -1, 1, 1'b0, 1'b0);
        chk("e2e.sw", score_o, sw_ref(NUM_PE));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
